moving_var_mc: RTL and testbench
================================

MOVING_VAR_MC -- requirements
Module: moving_var_mc

Interface
REQ-001 SHALL have parameter DIN_WIDTH, default 16, meaning signed input sample width.
REQ-002 SHALL have parameter DIN_POINT, default 15, meaning input fractional bits.
REQ-003 SHALL have parameter WINDOW_LEN, default 64, meaning samples per channel window, power of two, 2..4096.
REQ-004 SHALL have parameter N_CHANNELS, default 4, meaning interleaved channels, 1..64.
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1, meaning asynchronous, active-low reset.
REQ-007 SHALL have port din, input, DIN_WIDTH, meaning signed sample.
REQ-008 SHALL have port din_valid, input, 1, meaning din is accepted this cycle.
REQ-009 SHALL have port din_sync, input, 1, meaning the sample with din_valid high belongs to channel 0.
REQ-010 SHALL have port dout_mean, output, DIN_WIDTH, meaning signed windowed mean, point DIN_POINT.
REQ-011 SHALL have port dout_var, output, 2*DIN_WIDTH+1, meaning signed windowed variance, point 2*DIN_POINT.
REQ-012 SHALL have port dout_ch, output, clog2(N_CHANNELS) (min 1), meaning channel of the current result.
REQ-013 SHALL have port dout_warm, output, 1, meaning the window of dout_ch held WINDOW_LEN real samples.
REQ-014 SHALL have port dout_valid, output, 1, meaning the dout_* ports are valid this cycle.

Function
REQ-015 SHALL assign an internal channel counter to each valid sample, increment it after use, and wrap it from N_CHANNELS-1 to 0.
REQ-016 SHALL force the channel to 0 for a valid sample with din_sync high, then continue counting from 1.
REQ-017 SHALL ignore din_sync when din_valid is low.
REQ-018 SHALL keep per channel a running sum S (DIN_WIDTH+log2(WINDOW_LEN) bits) and a running sum of squares Q (2*DIN_WIDTH+log2(WINDOW_LEN) bits), both signed and exact with no wrap.
REQ-019 SHALL, per valid sample x of channel c, update S[c]+=x-x_old and Q[c]+=x*x-x_old*x_old, where x_old is channel c's sample WINDOW_LEN samples earlier.
REQ-020 SHALL use x_old=0 until channel c has received WINDOW_LEN samples since reset, so uninitialised delay memory never contributes.
REQ-021 SHALL compute mean as S>>>log2(WINDOW_LEN) (floor) and E[x^2] as Q>>>log2(WINDOW_LEN), each truncated to output precision.
REQ-022 SHALL compute dout_var as E[x^2]-mean*mean at full width 2*DIN_WIDTH+1.
REQ-023 SHALL assert dout_valid exactly 6 cycles after the accepting din_valid, one output per input, with no bubbles or reordering.
REQ-024 SHALL accept din_valid on every cycle, including back-to-back samples of the same channel when N_CHANNELS=1, with correct read-modify-write forwarding.
REQ-025 SHALL, when din_valid is low, advance no state other than the output pipeline.
REQ-026 SHALL keep dout_mean, dout_var and dout_ch at their last values while dout_valid is low.

Reset
REQ-027 SHALL, while rst is low, clear all S and Q, the channel counter and the fill counters, drop all in-flight samples, and drive every output to 0.
REQ-028 SHALL, on reset asserted mid-stream, restart warm-up from zero for every channel; delay-memory contents need not be cleared.
REQ-029 SHALL first produce dout_valid 6 cycles after the first valid sample following reset release.

Configuration
REQ-030 SHALL, with macro MOVING_VAR_MC_CLAMP_EN defined, replace a negative dout_var with 0.
REQ-031 SHALL, without MOVING_VAR_MC_CLAMP_EN, output the raw signed difference, which may be negative by at most the truncation error.

Structure
REQ-032 SHALL place in package moving_var_mc_pkg the clog2 helper, the LATENCY=6 constant, and the derived sum, square and output width constants.
REQ-033 SHALL implement the WINDOW_LEN*N_CHANNELS-entry sample delay as sub-module sample_delay_ram, a simple dual-port memory with one-cycle read latency and no reset.

Verification
REQ-034 SHALL cover: N_CHANNELS=1, WINDOW_LEN=4, DIN_POINT=0, din=2 every cycle -> after the 4th sample dout_warm=1, dout_mean=2, dout_var=0.
REQ-035 SHALL cover: N_CHANNELS=1, WINDOW_LEN=4, DIN_POINT=0, alternating +3,-3 -> once warm, dout_mean=0 and dout_var=9.
REQ-036 SHALL cover: N_CHANNELS=4 with channel k held at constant 10*k, din_sync on the channel-0 sample -> per-channel dout_mean=10*k, dout_var=0, and dout_ch cycling 0,1,2,3.
REQ-037 SHALL cover: din_valid toggling 1,0,0,1 -> each dout_valid exactly 6 cycles after its input, and outputs held between results.
REQ-038 SHALL cover: rst pulsed low after 100 samples -> all outputs 0 during reset, and dout_warm=0 for the next WINDOW_LEN samples per channel.
REQ-039 SHALL cover: DIN_WIDTH=16 with din=-32768 constant -> no overflow, dout_mean=-32768, dout_var=0 both with and without MOVING_VAR_MC_CLAMP_EN.

Source files
------------

// File: rtl/moving_var_mc_pkg.sv
// Shared constants and width helpers for the moving mean/variance block.
package moving_var_mc_pkg;

    // Cycles from an accepted sample to its result on the dout_* ports.
    localparam int LATENCY = 6;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r = r + 1;
        return r;
    endfunction

    // Channel index width, never narrower than one bit.
    function automatic int ch_width(input int n_channels);
        return (n_channels > 1) ? clog2(n_channels) : 1;
    endfunction

    // Running sum S: one sample width plus log2 of the window.
    function automatic int sum_width(input int din_width, input int window_len);
        return din_width + clog2(window_len);
    endfunction

    // Running sum of squares Q: square width plus log2 of the window.
    function automatic int sq_width(input int din_width, input int window_len);
        return 2 * din_width + clog2(window_len);
    endfunction

    // Variance output, also wide enough for a difference of two squares.
    function automatic int var_width(input int din_width);
        return 2 * din_width + 1;
    endfunction

endpackage

// File: rtl/moving_var_mc_if.sv
// Write/read port bundle between the moving_var_mc datapath and its sample delay memory.
interface moving_var_mc_if #(
    parameter int AW = 8,
    parameter int DW = 16
);
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [AW-1:0] raddr;
    logic [DW-1:0] rdata;

    modport master (output we, waddr, wdata, raddr, input rdata);
    modport slave  (input we, waddr, wdata, raddr, output rdata);
endinterface

// File: rtl/moving_var_mc_sample_delay_ram.sv
// Simple dual-port sample delay memory: one write port, one registered read port.
// A read and a write to the same address in one cycle return the old contents.
module sample_delay_ram
    import moving_var_mc_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = clog2(DEPTH),
    parameter int DW    = 16
) (
    input  logic           clk,
    moving_var_mc_if.slave ram
);

    // NOTE: storage has no reset so it maps onto block RAM; readers gate stale data themselves.
    logic [DW-1:0] mem_q [DEPTH];

    // Write the new sample and read the old one at the same edge.
    always_ff @(posedge clk) begin
        if (ram.we) begin
            mem_q[ram.waddr] <= ram.wdata;
        end
        ram.rdata <= mem_q[ram.raddr];
    end

endmodule

// File: rtl/moving_var_mc.sv
// Windowed mean and variance over interleaved channels.
// Optional build macro MOVING_VAR_MC_CLAMP_EN: negative variance results are forced to 0.
module moving_var_mc
    import moving_var_mc_pkg::*;
#(
    parameter int DIN_WIDTH  = 16,
    parameter int DIN_POINT  = 15,
    parameter int WINDOW_LEN = 64,
    parameter int N_CHANNELS = 4
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic signed [DIN_WIDTH-1:0]             din,
    input  logic                                    din_valid,
    input  logic                                    din_sync,
    output logic signed [DIN_WIDTH-1:0]             dout_mean,
    output logic signed [var_width(DIN_WIDTH)-1:0]  dout_var,
    output logic [ch_width(N_CHANNELS)-1:0]         dout_ch,
    output logic                                    dout_warm,
    output logic                                    dout_valid
);

    localparam int L     = clog2(WINDOW_LEN);
    localparam int CH_W  = ch_width(N_CHANNELS);
    localparam int SUM_W = sum_width(DIN_WIDTH, WINDOW_LEN);
    localparam int SQ_W  = sq_width(DIN_WIDTH, WINDOW_LEN);
    localparam int VAR_W = var_width(DIN_WIDTH);
    localparam int DEPTH = WINDOW_LEN * N_CHANNELS;
    localparam int AW    = clog2(DEPTH);

    localparam logic [CH_W-1:0] CH_LAST   = CH_W'(N_CHANNELS - 1);
    localparam logic [L:0]      FILL_FULL = (L + 1)'(WINDOW_LEN);
    localparam logic [L:0]      FILL_WARM = (L + 1)'(WINDOW_LEN - 1);

    if ((1 << L) != WINDOW_LEN || L < 1 || L > 12) begin : g_bad_window
        $error("WINDOW_LEN must be a power of two in 2..4096");
    end
    if (N_CHANNELS < 1 || N_CHANNELS > 64) begin : g_bad_channels
        $error("N_CHANNELS must be in 1..64");
    end
    if (DIN_POINT < 0 || DIN_POINT >= DIN_WIDTH) begin : g_bad_point
        $error("DIN_POINT must be in 0..DIN_WIDTH-1");
    end

    // ---------------- input stage: channel, delay pointer, fill state ----------------
    logic [CH_W-1:0] ch_cnt_q, ch_cnt_d, ch_in;
    logic [L-1:0]    ptr_q  [N_CHANNELS];
    logic [L:0]      fill_q [N_CHANNELS];
    logic [AW-1:0]   addr_in;
    logic            full_in, warm_in;

    // Resolve the channel of the incoming sample and its delay-line slot.
    always_comb begin
        // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
        ch_in    = din_sync ? '0 : ch_cnt_q;
        ch_cnt_d = (ch_in == CH_LAST) ? '0 : ch_in + CH_W'(1);
        full_in  = (fill_q[ch_in] == FILL_FULL);
        warm_in  = (fill_q[ch_in] >= FILL_WARM);
        addr_in  = AW'({ch_in, ptr_q[ch_in]});
    end

    // Channel counter, per-channel write pointer and fill count move only on accepted samples.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst) begin
            ch_cnt_q <= '0;
            for (int i = 0; i < N_CHANNELS; i++) begin
                ptr_q[i]  <= '0;
                fill_q[i] <= '0;
            end
        end else if (din_valid) begin
            ch_cnt_q     <= ch_cnt_d;
            ptr_q[ch_in] <= ptr_q[ch_in] + L'(1);
            if (!full_in) begin
                fill_q[ch_in] <= fill_q[ch_in] + (L + 1)'(1);
            end
        end
    end

    moving_var_mc_if #(.AW(AW), .DW(DIN_WIDTH)) ram_if ();

    assign ram_if.we    = din_valid;
    assign ram_if.waddr = addr_in;
    assign ram_if.wdata = din;
    assign ram_if.raddr = addr_in;

    sample_delay_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DIN_WIDTH)
    ) u_delay (
        .clk (clk),
        .ram (ram_if.slave)
    );

    // ---------------- datapath pipeline ----------------
    logic [LATENCY-1:0]          vld_q;
    logic signed [DIN_WIDTH-1:0] x1_q, x2_q, o2_q;
    logic [CH_W-1:0]             ch1_q, ch2_q, ch3_q, ch4_q, ch5_q;
    logic                        old1_q;
    logic                        warm1_q, warm2_q, warm3_q, warm4_q, warm5_q;
    logic signed [DIN_WIDTH:0]   ds3_q;
    logic signed [VAR_W-1:0]     dq3_q;
    logic signed [SUM_W-1:0]     s_q [N_CHANNELS];
    logic signed [SQ_W-1:0]      q_q [N_CHANNELS];
    logic signed [SUM_W-1:0]     s4_q;
    logic signed [SQ_W-1:0]      q4_q;
    logic signed [DIN_WIDTH-1:0] mean5_q;
    logic signed [VAR_W-1:0]     e2_5_q;

    logic signed [VAR_W-1:0]     x2_ext, o2_ext, mean5_ext;
    logic signed [DIN_WIDTH:0]   ds_d;
    logic signed [VAR_W-1:0]     dq_d;
    logic signed [SUM_W-1:0]     s_d;
    logic signed [SQ_W-1:0]      q_d;
    logic signed [VAR_W-1:0]     var_d;

    // Differences against the retiring sample, accumulator next values and the variance.
    always_comb begin
        x2_ext    = VAR_W'(x2_q);
        o2_ext    = VAR_W'(o2_q);
        ds_d      = (DIN_WIDTH + 1)'(x2_q) - (DIN_WIDTH + 1)'(o2_q);
        dq_d      = x2_ext * x2_ext - o2_ext * o2_ext;
        s_d       = s_q[ch3_q] + SUM_W'(ds3_q);
        q_d       = q_q[ch3_q] + SQ_W'(dq3_q);
        mean5_ext = VAR_W'(mean5_q);
        var_d     = e2_5_q - mean5_ext * mean5_ext;
`ifdef MOVING_VAR_MC_CLAMP_EN
        if (var_d[VAR_W-1]) begin
            var_d = '0;
        end
`endif
    end

    // Six-stage pipe: delay read, retire-mask, difference, accumulate, scale, output.
    // The accumulator update reads and writes its channel in the same cycle, so
    // back-to-back samples of one channel always see the freshest S and Q.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q   <= '0;
            x1_q    <= '0;
            ch1_q   <= '0;
            old1_q  <= 1'b0;
            warm1_q <= 1'b0;
            x2_q    <= '0;
            o2_q    <= '0;
            ch2_q   <= '0;
            warm2_q <= 1'b0;
            ds3_q   <= '0;
            dq3_q   <= '0;
            ch3_q   <= '0;
            warm3_q <= 1'b0;
            s4_q    <= '0;
            q4_q    <= '0;
            ch4_q   <= '0;
            warm4_q <= 1'b0;
            mean5_q <= '0;
            e2_5_q  <= '0;
            ch5_q   <= '0;
            warm5_q <= 1'b0;
            for (int i = 0; i < N_CHANNELS; i++) begin
                s_q[i] <= '0;
                q_q[i] <= '0;
            end
        end else begin
            vld_q   <= {vld_q[LATENCY-2:0], din_valid};
            // stage 1: sample captured while the delay memory returns the retiring one
            x1_q    <= din;
            ch1_q   <= ch_in;
            old1_q  <= full_in;
            warm1_q <= warm_in;
            // stage 2: retiring sample counts only once the channel's window has filled
            x2_q    <= x1_q;
            o2_q    <= old1_q ? ram_if.rdata : '0;
            ch2_q   <= ch1_q;
            warm2_q <= warm1_q;
            // stage 3: exact differences of values and of squares
            ds3_q   <= ds_d;
            dq3_q   <= dq_d;
            ch3_q   <= ch2_q;
            warm3_q <= warm2_q;
            // stage 4: per-channel accumulation
            if (vld_q[2]) begin
                s_q[ch3_q] <= s_d;
                q_q[ch3_q] <= q_d;
            end
            s4_q    <= s_d;
            q4_q    <= q_d;
            ch4_q   <= ch3_q;
            warm4_q <= warm3_q;
            // stage 5: divide by the window with floor rounding
            mean5_q <= DIN_WIDTH'(s4_q >>> L);
            e2_5_q  <= VAR_W'(q4_q >>> L);
            ch5_q   <= ch4_q;
            warm5_q <= warm4_q;
        end
    end

    // ---------------- output register ----------------
    logic signed [DIN_WIDTH-1:0] mean_q;
    logic signed [VAR_W-1:0]     var_q;
    logic [CH_W-1:0]             ch_q;
    logic                        warm_q;

    // Results load with their valid strobe and hold in between.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mean_q <= '0;
            var_q  <= '0;
            ch_q   <= '0;
            warm_q <= 1'b0;
        end else if (vld_q[LATENCY-2]) begin
            mean_q <= mean5_q;
            var_q  <= var_d;
            ch_q   <= ch5_q;
            warm_q <= warm5_q;
        end
    end

    assign dout_mean  = mean_q;
    assign dout_var   = var_q;
    assign dout_ch    = ch_q;
    assign dout_warm  = warm_q;
    assign dout_valid = vld_q[LATENCY-1];

endmodule

// File: tb/tb_moving_var_mc.sv
// Self-checking bench for moving_var_mc: two instances (1 channel / window 4, and
// 4 channels / window 8) checked against a window-history reference model.
module tb_moving_var_mc;

    localparam int DW   = 16;
    localparam int VW   = 2 * DW + 1;
    localparam int HMAX = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mon_en = 1'b0;
    longint cyc = 0;
    int checks = 0;
    int failures = 0;

    logic signed [DW-1:0] a_din = '0, b_din = '0;
    logic a_valid = 1'b0, a_sync = 1'b0, b_valid = 1'b0, b_sync = 1'b0;
    logic signed [DW-1:0] a_mean, b_mean;
    logic signed [VW-1:0] a_var, b_var;
    logic [0:0] a_ch;
    logic [1:0] b_ch;
    logic a_warm, b_warm, a_dv, b_dv;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    moving_var_mc #(.DIN_WIDTH(DW), .DIN_POINT(0), .WINDOW_LEN(4), .N_CHANNELS(1)) dut_a (
        .clk(clk), .rst(rst), .din(a_din), .din_valid(a_valid), .din_sync(a_sync),
        .dout_mean(a_mean), .dout_var(a_var), .dout_ch(a_ch), .dout_warm(a_warm),
        .dout_valid(a_dv));

    moving_var_mc #(.DIN_WIDTH(DW), .DIN_POINT(15), .WINDOW_LEN(8), .N_CHANNELS(4)) dut_b (
        .clk(clk), .rst(rst), .din(b_din), .din_valid(b_valid), .din_sync(b_sync),
        .dout_mean(b_mean), .dout_var(b_var), .dout_ch(b_ch), .dout_warm(b_warm),
        .dout_valid(b_dv));

    // ---------------- reference model ----------------
    typedef struct {
        longint mean;
        longint var_v;
        int     ch;
        bit     warm;
        longint cyc;
    } exp_t;

    longint hist [2][4][HMAX];
    int     hcnt [2][4];
    int     ch_cnt [2];
    exp_t   exp_a[$];
    exp_t   exp_b[$];
    longint last_mean [2];
    longint last_var [2];
    longint last_ch [2];

    function automatic int win_of(input int d);
        return (d == 0) ? 4 : 8;
    endfunction

    function automatic int nch_of(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    function automatic longint floor_div(input longint a, input longint b);
        if (a >= 0) return a / b;
        return -((-a + b - 1) / b);
    endfunction

    function automatic void model_clear();
        for (int d = 0; d < 2; d++) begin
            ch_cnt[d] = 0;
            last_mean[d] = 0;
            last_var[d] = 0;
            last_ch[d] = 0;
            for (int c = 0; c < 4; c++) hcnt[d][c] = 0;
        end
        exp_a.delete();
        exp_b.delete();
    endfunction

    // Window = the channel's last WINDOW_LEN samples since reset (missing ones count as 0).
    function automatic exp_t model_push(input int d, input bit sync, input longint x, input longint due);
        exp_t e;
        int c, n, w;
        longint s, q, v;
        w = win_of(d);
        c = sync ? 0 : ch_cnt[d];
        ch_cnt[d] = (c + 1) % nch_of(d);
        hist[d][c][hcnt[d][c] % HMAX] = x;
        hcnt[d][c]++;
        n = (hcnt[d][c] < w) ? hcnt[d][c] : w;
        s = 0;
        q = 0;
        for (int i = 0; i < n; i++) begin
            v = hist[d][c][(hcnt[d][c] - 1 - i) % HMAX];
            s += v;
            q += v * v;
        end
        e.mean  = floor_div(s, w);
        e.var_v = floor_div(q, w) - e.mean * e.mean;
`ifdef MOVING_VAR_MC_CLAMP_EN
        if (e.var_v < 0) e.var_v = 0;
`endif
        e.ch   = c;
        e.warm = (hcnt[d][c] >= w);
        e.cyc  = due;
        return e;
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic mon(input int d, input bit dv, input longint mean, input longint var_v,
                       input longint ch, input bit warm);
        exp_t e;
        bit have;
        string p;
        p = (d == 0) ? "a" : "b";
        have = (d == 0) ? (exp_a.size() > 0) : (exp_b.size() > 0);
        if (have) e = (d == 0) ? exp_a[0] : exp_b[0];
        if (dv) begin
            check({p, "_expected_result"}, have, 1);
            if (have) begin
                if (d == 0) void'(exp_a.pop_front()); else void'(exp_b.pop_front());
                check({p, "_latency_cycle"}, cyc, e.cyc);
                check({p, "_mean"}, mean, e.mean);
                check({p, "_var"}, var_v, e.var_v);
                check({p, "_ch"}, ch, e.ch);
                check({p, "_warm"}, warm, e.warm);
                last_mean[d] = e.mean;
                last_var[d]  = e.var_v;
                last_ch[d]   = e.ch;
            end
        end else begin
            if (have && e.cyc <= cyc) begin
                check({p, "_dout_valid_due"}, dv, 1);
                if (d == 0) void'(exp_a.pop_front()); else void'(exp_b.pop_front());
            end
            check({p, "_hold_mean"}, mean, last_mean[d]);
            check({p, "_hold_var"}, var_v, last_var[d]);
            check({p, "_hold_ch"}, ch, last_ch[d]);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && rst) begin
            mon(0, a_dv, a_mean, a_var, a_ch, a_warm);
            mon(1, b_dv, b_mean, b_var, b_ch, b_warm);
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input int d, input bit v, input bit s, input longint x);
        exp_t e;
        @(negedge clk);
        a_valid = 1'b0;
        a_sync  = 1'b0;
        b_valid = 1'b0;
        b_sync  = 1'b0;
        if (d == 0) begin
            a_valid = v;
            a_sync  = s;
            a_din   = DW'(x);
        end else begin
            b_valid = v;
            b_sync  = s;
            b_din   = DW'(x);
        end
        if (v) begin
            e = model_push(d, s, x, cyc + 6);
            if (d == 0) exp_a.push_back(e); else exp_b.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) send(0, 1'b0, 1'b0, 0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_a_mean"}, a_mean, 0);
        check({tag, "_a_var"}, a_var, 0);
        check({tag, "_a_ch"}, a_ch, 0);
        check({tag, "_a_warm"}, a_warm, 0);
        check({tag, "_a_valid"}, a_dv, 0);
        check({tag, "_b_mean"}, b_mean, 0);
        check({tag, "_b_var"}, b_var, 0);
        check({tag, "_b_ch"}, b_ch, 0);
        check({tag, "_b_warm"}, b_warm, 0);
        check({tag, "_b_valid"}, b_dv, 0);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b0;
        a_valid = 1'b0;
        b_valid = 1'b0;
        a_sync  = 1'b0;
        b_sync  = 1'b0;
        model_clear();
        #1;
        check_zero_outputs("rst_enter");
        repeat (n) @(negedge clk);
        check_zero_outputs("rst_hold");
        rst = 1'b1;
        mon_en = 1'b1;
    endtask

    function automatic longint rnd_sample();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return -32768;
        if (r == 1) return 32767;
        return longint'($urandom_range(0, 65535)) - 32768;
    endfunction

    initial begin
        longint neg_var_exp;
        int nb;
        bit v;

        do_reset(3);

        // Constant 2 on the single-channel instance.
        for (int i = 0; i < 8; i++) send(0, 1'b1, 1'b0, 2);
        idle(8);
        check("a_const2_mean", a_mean, 2);
        check("a_const2_var", a_var, 0);
        check("a_const2_warm", a_warm, 1);

        // Alternating +3/-3.
        for (int i = 0; i < 8; i++) send(0, 1'b1, 1'b0, (i % 2 == 0) ? 3 : -3);
        idle(8);
        check("a_alt3_mean", a_mean, 0);
        check("a_alt3_var", a_var, 9);

        // Window -1,0,0,0: floor truncation drives the raw variance negative.
`ifdef MOVING_VAR_MC_CLAMP_EN
        neg_var_exp = 0;
`else
        neg_var_exp = -1;
`endif
        send(0, 1'b1, 1'b0, -1);
        for (int i = 0; i < 3; i++) send(0, 1'b1, 1'b0, 0);
        idle(8);
        check("a_negvar_mean", a_mean, -1);
        check("a_negvar_var", a_var, neg_var_exp);

        // Most negative input held constant.
        for (int i = 0; i < 8; i++) send(0, 1'b1, 1'b0, -32768);
        idle(8);
        check("a_minval_mean", a_mean, -32768);
        check("a_minval_var", a_var, 0);

        // Valid pattern 1,0,0 repeating; sync toggled while valid is low.
        for (int i = 0; i < 6; i++) begin
            send(0, 1'b1, 1'b0, rnd_sample());
            send(0, 1'b0, 1'b1, rnd_sample());
            send(0, 1'b0, 1'b0, rnd_sample());
        end

        // Back-to-back random samples on one channel.
        for (int i = 0; i < 80; i++) send(0, 1'b1, 1'b0, rnd_sample());
        idle(8);

        // Four channels held at 10*k, sync on the channel-0 sample.
        for (int r = 0; r < 10; r++)
            for (int k = 0; k < 4; k++) send(1, 1'b1, k == 0, 10 * k);
        idle(8);
        check("b_const_ch", b_ch, 3);
        check("b_const_mean", b_mean, 30);
        check("b_const_var", b_var, 0);
        check("b_const_warm", b_warm, 1);

        // Random traffic, then a mid-stream reset after 100 accepted samples.
        nb = 0;
        while (nb < 100) begin
            v = ($urandom_range(0, 3) != 0);
            send(1, v, ($urandom_range(0, 19) == 0), rnd_sample());
            if (v) nb++;
        end
        do_reset(2);

        // Warm-up restarts from zero for every channel.
        for (int i = 0; i < 200; i++) begin
            v = ($urandom_range(0, 3) != 0);
            send(1, v, ($urandom_range(0, 29) == 0), rnd_sample());
        end
        for (int i = 0; i < 60; i++) send(0, ($urandom_range(0, 1) == 1), 1'b0, rnd_sample());
        idle(10);

        check("a_drained", exp_a.size(), 0);
        check("b_drained", exp_b.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
